ball_motion_ctl: RTL and testbench



---
 rtl/ball_motion_ctl_pkg.sv | 59 +++++
 rtl/ball_motion_ctl_if.sv | 35 +++
 rtl/ball_motion_ctl_circle_hit.sv | 37 +++
 rtl/ball_motion_ctl.sv | 227 ++++++++++++++++++++++
 tb/tb_ball_motion_ctl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_motion_ctl_pkg.sv
// Shared definitions for the puck motion controller: table geometry, serve
// point, goal mouth, velocity limits, friction period, kick scaling, the
// controller state encoding, and small width-conversion helpers.
package ball_motion_ctl_pkg;

    localparam int RADIUS       = 10;
    localparam int CENTER_X     = 487;
    localparam int CENTER_Y     = 362;
    localparam int TABLE_LEFT   = 87;
    localparam int TABLE_RIGHT  = 887;
    localparam int TABLE_TOP    = 112;
    localparam int TABLE_BOTTOM = 612;
    localparam int GOAL_TOP     = 312;
    localparam int GOAL_BOT     = 412;
    localparam int VMAX         = 15;
    localparam int FRIC_FRAMES  = 8;
    localparam int KICK_SHIFT   = 2;

    localparam int POS_W  = 12;
    localparam int VEL_W  = 6;
    localparam int SPOS_W = 13;
    localparam int FRIC_W = $clog2(FRIC_FRAMES);

    typedef logic signed [VEL_W-1:0]  vel_t;
    typedef logic signed [SPOS_W-1:0] spos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WALL,
        ST_HIT1,
        ST_HIT2,
        ST_FRIC,
        ST_COMMIT
    } state_t;

    // Wall tests are done on the centre: "centre - R < wall" is "centre < wall + R".
    localparam spos_t LEFT_MIN   = spos_t'(TABLE_LEFT + RADIUS);
    localparam spos_t RIGHT_MAX  = spos_t'(TABLE_RIGHT - RADIUS);
    localparam spos_t TOP_MIN    = spos_t'(TABLE_TOP + RADIUS);
    localparam spos_t BOT_MAX    = spos_t'(TABLE_BOTTOM - RADIUS);
    localparam spos_t GOAL_TOP_S = spos_t'(GOAL_TOP);
    localparam spos_t GOAL_BOT_S = spos_t'(GOAL_BOT);
    localparam spos_t CENTER_X_S = spos_t'(CENTER_X);
    localparam spos_t CENTER_Y_S = spos_t'(CENTER_Y);

    localparam logic [POS_W-1:0] CENTER_X_P = POS_W'(CENTER_X);
    localparam logic [POS_W-1:0] CENTER_Y_P = POS_W'(CENTER_Y);
    localparam logic [7:0]       RADIUS_P   = 8'(RADIUS);

    function automatic spos_t pos_to_spos(input logic [POS_W-1:0] p);
        return spos_t'({1'b0, p});
    endfunction

    function automatic spos_t vel_to_spos(input vel_t v);
        return spos_t'({{(SPOS_W-VEL_W){v[VEL_W-1]}}, v});
    endfunction

endpackage

// File: rtl/ball_motion_ctl_if.sv
// Bus between the timing/mallet side and the puck motion controller.
//   vblnk_in            vertical blank from the timing chain
//   xpos_p1/ypos_p1     mallet 1 centre
//   xpos_p2/ypos_p2     mallet 2 centre
//   radius_player       mallet radius, px
//   xpos/ypos           puck centre (changes only during vertical blank)
//   goal_left/right     1-clk pulse when the puck enters a goal
//   frame_done          1-clk pulse when a frame update is committed
// The controller uses the slave view; whoever drives mallets/blanking uses master.
interface ball_motion_ctl_if;
    import ball_motion_ctl_pkg::*;

    logic             vblnk_in;
    logic [POS_W-1:0] xpos_p1;
    logic [POS_W-1:0] ypos_p1;
    logic [POS_W-1:0] xpos_p2;
    logic [POS_W-1:0] ypos_p2;
    logic [7:0]       radius_player;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             goal_left;
    logic             goal_right;
    logic             frame_done;

    modport slave (
        input  vblnk_in, xpos_p1, ypos_p1, xpos_p2, ypos_p2, radius_player,
        output xpos, ypos, goal_left, goal_right, frame_done
    );

    modport master (
        output vblnk_in, xpos_p1, ypos_p1, xpos_p2, ypos_p2, radius_player,
        input  xpos, ypos, goal_left, goal_right, frame_done
    );

endinterface

// File: rtl/ball_motion_ctl_circle_hit.sv
// circle_hit: combinational test whether two circles touch or overlap,
// i.e. (x1-x2)^2 + (y1-y2)^2 <= (r1+r2)^2.
//   x1,y1,r1   first circle centre and radius
//   x2,y2,r2   second circle centre and radius
//   hit        1 when the circles touch or overlap
// Absolute differences keep the squares unsigned; the 25-bit sum of two
// 12-bit squares cannot overflow.
module circle_hit
    import ball_motion_ctl_pkg::*;
(
    input  logic [POS_W-1:0] x1,
    input  logic [POS_W-1:0] y1,
    input  logic [7:0]       r1,
    input  logic [POS_W-1:0] x2,
    input  logic [POS_W-1:0] y2,
    input  logic [7:0]       r2,
    output logic             hit
);

    logic [POS_W-1:0]     dx;
    logic [POS_W-1:0]     dy;
    logic [2*POS_W-1:0]   dx2;
    logic [2*POS_W-1:0]   dy2;
    logic [2*POS_W:0]     dist2;
    logic [8:0]           rsum;
    logic [17:0]          rsq;

    assign dx    = (x1 >= x2) ? (x1 - x2) : (x2 - x1);
    assign dy    = (y1 >= y2) ? (y1 - y2) : (y2 - y1);
    assign dx2   = {{POS_W{1'b0}}, dx} * {{POS_W{1'b0}}, dx};
    assign dy2   = {{POS_W{1'b0}}, dy} * {{POS_W{1'b0}}, dy};
    assign dist2 = {1'b0, dx2} + {1'b0, dy2};
    assign rsum  = {1'b0, r1} + {1'b0, r2};
    assign rsq   = {9'd0, rsum} * {9'd0, rsum};
    assign hit   = (dist2 <= {7'd0, rsq});

endmodule

// File: rtl/ball_motion_ctl.sv
// ball_motion_ctl: per-frame puck physics. On each rising edge of vblnk_in
// the controller walks MOVE -> WALL -> HIT1 -> HIT2 -> FRIC -> COMMIT, one
// state per clock, and publishes the new puck centre at COMMIT, so the
// outputs only move during vertical blanking.
//   clk_in   pixel clock
//   rst      asynchronous active-high reset
//   bus      slave view of ball_motion_ctl_if (blanking, mallets in; puck,
//            goal pulses and frame_done out)
module ball_motion_ctl
    import ball_motion_ctl_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    ball_motion_ctl_if.slave bus
);

    localparam logic signed [POS_W+1:0] KICK_HI   = (POS_W+2)'(VMAX);
    localparam logic signed [POS_W+1:0] KICK_LO   = (POS_W+2)'(-VMAX);
    localparam logic [FRIC_W-1:0]       FRIC_LAST = FRIC_W'(FRIC_FRAMES - 1);

    // Kick velocity: offset scaled down by an arithmetic shift, saturated to +-VMAX.
    function automatic vel_t sat_kick(input logic signed [POS_W+1:0] off);
        logic signed [POS_W+1:0] sh;
        sh = off >>> KICK_SHIFT;
        if (sh > KICK_HI) begin
            return vel_t'(VMAX);
        end else if (sh < KICK_LO) begin
            return vel_t'(-VMAX);
        end
        return sh[VEL_W-1:0];
    endfunction

    // Friction step: one unit toward zero, never across it.
    function automatic vel_t toward_zero(input vel_t v);
        if (v > 6'sd0) begin
            return v - 6'sd1;
        end else if (v < 6'sd0) begin
            return v + 6'sd1;
        end
        return v;
    endfunction

    state_t             state_q, state_d;
    logic               vblnk_q, vblnk_d;
    logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
    vel_t               vx_q, vx_d, vy_q, vy_d;
    logic [FRIC_W-1:0]  cnt_q, cnt_d;
    logic               goal_left_q, goal_left_d;
    logic               goal_right_q, goal_right_d;
    logic               frame_done_q, frame_done_d;
    spos_t              nx_q, nx_d, ny_q, ny_d;

    logic               tick;
    logic               in_mouth;
    logic               out_left, out_right, out_top, out_bot;
    logic               hit;
    logic [POS_W-1:0]   mal_x, mal_y;
    logic signed [POS_W+1:0] off_x, off_y;
    vel_t               kick_vx, kick_vy;

    assign tick = bus.vblnk_in & ~vblnk_q;

    // The goal mouth is tested on the unreflected y; the mouth lies well inside
    // the top/bottom limits, so a reflected y could never be in it anyway.
    assign in_mouth  = (ny_q >= GOAL_TOP_S) && (ny_q <= GOAL_BOT_S);
    assign out_left  = (nx_q < LEFT_MIN);
    assign out_right = (nx_q > RIGHT_MAX);
    assign out_top   = (ny_q < TOP_MIN);
    assign out_bot   = (ny_q > BOT_MAX);

    // One distance checker shared by both mallets; HIT2 selects mallet 2.
    assign mal_x = (state_q == ST_HIT2) ? bus.xpos_p2 : bus.xpos_p1;
    assign mal_y = (state_q == ST_HIT2) ? bus.ypos_p2 : bus.ypos_p1;

    // During HIT states the centre has been clamped inside the table, so the
    // low 12 bits carry the full (non-negative) position.
    circle_hit u_hit (
        .x1 (nx_q[POS_W-1:0]),
        .y1 (ny_q[POS_W-1:0]),
        .r1 (RADIUS_P),
        .x2 (mal_x),
        .y2 (mal_y),
        .r2 (bus.radius_player),
        .hit(hit)
    );

    always_comb begin
        off_x   = {nx_q[SPOS_W-1], nx_q} - {2'b00, mal_x};
        off_y   = {ny_q[SPOS_W-1], ny_q} - {2'b00, mal_y};
        kick_vx = sat_kick(off_x);
        kick_vy = sat_kick(off_y);
        // A touching mallet must always push the puck; break a zero/zero kick
        // along x away from the mallet.
        if (kick_vx == '0 && kick_vy == '0) begin
            kick_vx = off_x[POS_W+1] ? -6'sd1 : 6'sd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        vblnk_d      = bus.vblnk_in;
        x_d          = x_q;
        y_d          = y_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        cnt_d        = cnt_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        goal_left_d  = 1'b0;
        goal_right_d = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                nx_d    = pos_to_spos(x_q) + vel_to_spos(vx_q);
                ny_d    = pos_to_spos(y_q) + vel_to_spos(vy_q);
                state_d = ST_WALL;
            end
            ST_WALL: begin
                if (out_top) begin
                    ny_d = TOP_MIN;
                    vy_d = -vy_q;
                end else if (out_bot) begin
                    ny_d = BOT_MAX;
                    vy_d = -vy_q;
                end
                if ((out_left || out_right) && in_mouth) begin
                    nx_d         = CENTER_X_S;
                    ny_d         = CENTER_Y_S;
                    vx_d         = '0;
                    vy_d         = '0;
                    goal_left_d  = out_left;
                    goal_right_d = out_right;
                    state_d      = ST_COMMIT;
                end else begin
                    if (out_left) begin
                        nx_d = LEFT_MIN;
                        vx_d = -vx_q;
                    end else if (out_right) begin
                        nx_d = RIGHT_MAX;
                        vx_d = -vx_q;
                    end
                    state_d = ST_HIT1;
                end
            end
            ST_HIT1: begin
                if (hit) begin
                    vx_d    = kick_vx;
                    vy_d    = kick_vy;
                    state_d = ST_FRIC;
                end else begin
                    state_d = ST_HIT2;
                end
            end
            ST_HIT2: begin
                if (hit) begin
                    vx_d = kick_vx;
                    vy_d = kick_vy;
                end
                state_d = ST_FRIC;
            end
            ST_FRIC: begin
                if (cnt_q == FRIC_LAST) begin
                    cnt_d = '0;
                    vx_d  = toward_zero(vx_q);
                    vy_d  = toward_zero(vy_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                x_d          = nx_q[POS_W-1:0];
                y_d          = ny_q[POS_W-1:0];
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vblnk_q      <= 1'b0;
            x_q          <= CENTER_X_P;
            y_q          <= CENTER_Y_P;
            vx_q         <= '0;
            vy_q         <= '0;
            cnt_q        <= '0;
            goal_left_q  <= 1'b0;
            goal_right_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vblnk_q      <= vblnk_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            cnt_q        <= cnt_d;
            goal_left_q  <= goal_left_d;
            goal_right_q <= goal_right_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scratch position is always rewritten in MOVE before use, so it needs no reset.
    always_ff @(posedge clk_in) begin
        nx_q <= nx_d;
        ny_q <= ny_d;
    end

    assign bus.xpos       = x_q;
    assign bus.ypos       = y_q;
    assign bus.goal_left  = goal_left_q;
    assign bus.goal_right = goal_right_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ball_motion_ctl.sv
module tb_ball_motion_ctl;
    import ball_motion_ctl_pkg::*;

    localparam int FAR = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ball_motion_ctl_if bus();

    ball_motion_ctl dut (
        .clk_in(clk),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state (plain integers).
    int m_x, m_y, m_vx, m_vy, m_cnt;

    typedef struct {
        bit rst_before;
        int p1x, p1y, p2x, p2y, r;
        int ex, ey;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void add_row(input bit rb, input int p1x, p1y, p2x, p2y, r, ex, ey);
        vec_t v;
        v.rst_before = rb;
        v.p1x = p1x; v.p1y = p1y; v.p2x = p2x; v.p2y = p2y; v.r = r;
        v.ex = ex; v.ey = ey;
        tbl.push_back(v);
    endfunction

    function automatic int floor_div4(input int d);
        if (d >= 0) return d / 4;
        return -((-d + 3) / 4);
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit touching(input int ax, ay, bx, by, br);
        return ((ax - bx) * (ax - bx) + (ay - by) * (ay - by)) <= ((10 + br) * (10 + br));
    endfunction

    task automatic model_reset();
        m_x = 487; m_y = 362; m_vx = 0; m_vy = 0; m_cnt = 0;
    endtask

    task automatic model_kick(input int nx, ny, px, py);
        int kx, ky;
        kx = clamp(floor_div4(nx - px), -15, 15);
        ky = clamp(floor_div4(ny - py), -15, 15);
        if (kx == 0 && ky == 0) kx = (nx >= px) ? 1 : -1;
        m_vx = kx;
        m_vy = ky;
    endtask

    // One frame of puck physics; lat = clocks from the tick edge to frame_done.
    task automatic model_frame(input int p1x, p1y, p2x, p2y, pr, output int gl, gr, lat);
        int nx, ny, oy;
        bit h1, h2;
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        oy = ny;
        gl = 0; gr = 0;
        if (ny - 10 < 112) begin ny = 122; m_vy = -m_vy; end
        else if (ny + 10 > 612) begin ny = 602; m_vy = -m_vy; end
        if (nx - 10 < 87) begin
            if (oy >= 312 && oy <= 412) gl = 1;
            else begin nx = 97; m_vx = -m_vx; end
        end else if (nx + 10 > 887) begin
            if (oy >= 312 && oy <= 412) gr = 1;
            else begin nx = 877; m_vx = -m_vx; end
        end
        if (gl != 0 || gr != 0) begin
            m_x = 487; m_y = 362; m_vx = 0; m_vy = 0;
            lat = 3;
        end else begin
            h1 = touching(nx, ny, p1x, p1y, pr);
            h2 = touching(nx, ny, p2x, p2y, pr);
            if (h1) model_kick(nx, ny, p1x, p1y);
            else if (h2) model_kick(nx, ny, p2x, p2y);
            lat = h1 ? 5 : 6;
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (m_vx > 0) m_vx--; else if (m_vx < 0) m_vx++;
                if (m_vy > 0) m_vy--; else if (m_vy < 0) m_vy++;
            end
            m_x = nx;
            m_y = ny;
        end
    endtask

    task automatic set_mallets(input int p1x, p1y, p2x, p2y, r);
        bus.xpos_p1       = 12'(p1x);
        bus.ypos_p1       = 12'(p1y);
        bus.xpos_p2       = 12'(p2x);
        bus.ypos_p2       = 12'(p2y);
        bus.radius_player = 8'(r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.vblnk_in = 1'b0;
        set_mallets(FAR, FAR, FAR, FAR, 20);
        @(negedge clk);
        @(negedge clk);
        check("rst_xpos", int'(bus.xpos), 487);
        check("rst_ypos", int'(bus.ypos), 362);
        check("rst_goal_left", int'(bus.goal_left), 0);
        check("rst_goal_right", int'(bus.goal_right), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Runs one frame against the model; a glitch re-raises vblnk mid-update,
    // which must be ignored.
    task automatic run_frame(input int p1x, p1y, p2x, p2y, r, input bit glitch,
                             output int got_x, output int got_y);
        int ox, oy, egl, egr, elat;
        int fd_k, nfd, ngl, ngr;
        bit moved;
        ox = m_x; oy = m_y;
        set_mallets(p1x, p1y, p2x, p2y, r);
        model_frame(p1x, p1y, p2x, p2y, r, egl, egr, elat);
        fd_k = 0; nfd = 0; ngl = 0; ngr = 0; moved = 0;
        got_x = -1; got_y = -1;
        @(negedge clk);
        bus.vblnk_in = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                nfd++;
                if (fd_k == 0) begin
                    fd_k  = k;
                    got_x = int'(bus.xpos);
                    got_y = int'(bus.ypos);
                end
            end else if (fd_k == 0 && (int'(bus.xpos) != ox || int'(bus.ypos) != oy)) begin
                moved = 1;
            end
            if (bus.goal_left)  ngl++;
            if (bus.goal_right) ngr++;
            if (glitch && k == 1) bus.vblnk_in = 1'b0;
            if (glitch && k == 2) bus.vblnk_in = 1'b1;
        end
        bus.vblnk_in = 1'b0;
        @(negedge clk);
        check("frame_latency", fd_k - 1, elat);
        check("frame_done_pulses", nfd, 1);
        check("goal_left_pulses", ngl, egl);
        check("goal_right_pulses", ngr, egr);
        check("xpos_model", got_x, m_x);
        check("ypos_model", got_y, m_y);
        check("no_early_change", int'(moved), 0);
    endtask

    function automatic int near(input int c);
        return clamp(c + int'($urandom_range(0, 80)) - 40, 0, 4095);
    endfunction

    initial begin
        int gx, gy, sel, r;
        int a1x, a1y, a2x, a2y;

        bus.vblnk_in = 1'b0;
        set_mallets(FAR, FAR, FAR, FAR, 20);
        model_reset();

        // Idle frames, single kick with friction decay, mallet 1 priority.
        for (int i = 0; i < 10; i++) add_row(i == 0, FAR, FAR, FAR, FAR, 20, 487, 362);
        add_row(1, 477, 362, FAR, FAR, 20, 487, 362);
        for (int i = 0; i < 7; i++) add_row(0, FAR, FAR, FAR, FAR, 20, 489 + 2 * i, 362);
        for (int i = 0; i < 8; i++) add_row(0, FAR, FAR, FAR, FAR, 20, 502 + i, 362);
        add_row(0, FAR, FAR, FAR, FAR, 20, 509, 362);
        add_row(0, FAR, FAR, FAR, FAR, 20, 509, 362);
        add_row(0, 499, 362, 519, 362, 20, 509, 362);
        add_row(0, FAR, FAR, FAR, FAR, 20, 511, 362);
        add_row(0, FAR, FAR, FAR, FAR, 20, 513, 362);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            run_frame(tbl[i].p1x, tbl[i].p1y, tbl[i].p2x, tbl[i].p2y, tbl[i].r,
                      (i % 4) == 1, gx, gy);
            check("tbl_xpos", gx, tbl[i].ex);
            check("tbl_ypos", gy, tbl[i].ey);
        end

        // Reset asserted while the controller sits in HIT1.
        set_mallets(FAR, FAR, FAR, FAR, 20);
        @(negedge clk);
        bus.vblnk_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_xpos", int'(bus.xpos), 487);
        check("midrst_ypos", int'(bus.ypos), 362);
        bus.vblnk_in = 1'b0;
        @(negedge clk);
        check("midrst_frame_done", int'(bus.frame_done), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_frame(FAR, FAR, FAR, FAR, 20, 0, gx, gy);
        check("post_rst_xpos", gx, 487);
        run_frame(477, 362, FAR, FAR, 20, 0, gx, gy);
        run_frame(FAR, FAR, FAR, FAR, 20, 0, gx, gy);
        check("post_rst_kick_xpos", gx, 489);

        // Hard kicks toward the left goal, the right goal, and a diagonal into the walls.
        do_reset();
        run_frame(547, 362, FAR, FAR, 70, 0, gx, gy);
        for (int i = 0; i < 40; i++) run_frame(FAR, FAR, FAR, FAR, 20, i % 5 == 0, gx, gy);
        run_frame(427, 362, FAR, FAR, 70, 0, gx, gy);
        for (int i = 0; i < 40; i++) run_frame(FAR, FAR, FAR, FAR, 20, 0, gx, gy);
        run_frame(427, 402, FAR, FAR, 70, 0, gx, gy);
        for (int i = 0; i < 60; i++) run_frame(FAR, FAR, FAR, FAR, 20, 0, gx, gy);
        run_frame(547, 302, FAR, FAR, 80, 0, gx, gy);
        for (int i = 0; i < 60; i++) run_frame(FAR, FAR, FAR, FAR, 20, 0, gx, gy);

        // Randomised mallet placement around the puck.
        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 9));
            r   = int'($urandom_range(4, 60));
            a1x = FAR; a1y = FAR; a2x = FAR; a2y = FAR;
            if (sel <= 1 || sel == 3) begin a1x = near(m_x); a1y = near(m_y); end
            if (sel == 2 || sel == 3) begin a2x = near(m_x); a2y = near(m_y); end
            run_frame(a1x, a1y, a2x, a2y, r, sel == 4, gx, gy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
